// File: rtl/regio_arbiter.sv
// Arbitrates the single RegIO register-access port among NUM_REQ requesters.
// Requester 0 owns the port until init_done; afterwards round-robin with optional burst lock.
module regio_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk40m,
    input  logic                  reset,
    input  logic                  init_done,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*8-1:0]  req_offset,
    input  logic [NUM_REQ-1:0]    req_length,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*16-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    err,
    output logic [15:0]           rdata,
    output logic [7:0]            offset,
    output logic                  length,
    output logic                  WR,
    output logic [15:0]           writeData,
    output logic                  NewCommand,
    input  logic [15:0]           readData,
    input  logic                  io_done
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]   lock_owner_q, lock_owner_d;
    logic [7:0]         timer_q, timer_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [15:0]        rdata_q, rdata_d;
    logic [7:0]         offset_q, offset_d;
    logic               length_q, length_d;
    logic               wr_q, wr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               new_cmd_q, new_cmd_d;

    logic [NUM_REQ-1:0] elig;
    logic               win;
    logic [IDX_W-1:0]   win_idx;
    int                 idx;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        timer_d      = timer_q;
        grant_d      = grant_q;
        ack_d        = '0;
        err_d        = '0;
        rdata_d      = rdata_q;
        offset_d     = offset_q;
        length_d     = length_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        new_cmd_d    = 1'b0;
        win          = 1'b0;
        win_idx      = '0;
        idx          = 0;
        elig         = init_done ? req : (req & NUM_REQ'(1));

        case (state_q)
            IDLE: begin
                // A lock is only honoured while its owner is still eligible to hold it.
                if (lock_valid_q && req[lock_owner_q] && (init_done || lock_owner_q == '0)) begin
                    win     = 1'b1;
                    win_idx = lock_owner_q;
                end else begin
                    lock_valid_d = 1'b0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        idx = (int'(ptr_q) + i) % NUM_REQ;
                        if (!win && elig[idx]) begin
                            win     = 1'b1;
                            win_idx = IDX_W'(idx);
                        end
                    end
                end
                if (win) begin
                    owner_d          = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    offset_d         = req_offset[int'(win_idx)*8 +: 8];
                    length_d         = req_length[win_idx];
                    wr_d             = req_wr[win_idx];
                    wdata_d          = req_wdata[int'(win_idx)*16 +: 16];
                    new_cmd_d        = 1'b1;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 8'd1;
                if (io_done) begin
                    rdata_d = readData;
                    ack_d   = grant_q;
                    state_d = DONE;
                end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    ack_d   = grant_q;
                    err_d   = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                lock_valid_d = req_lock[owner_q];
                lock_owner_d = owner_q;
                ptr_d        = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Before init completes only the init sequencer may keep a lock.
        if (!init_done && lock_owner_d != '0) lock_valid_d = 1'b0;
    end

    always_ff @(posedge clk40m or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            timer_q      <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            offset_q     <= '0;
            length_q     <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            new_cmd_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            timer_q      <= timer_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            offset_q     <= offset_d;
            length_q     <= length_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            new_cmd_q    <= new_cmd_d;
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign offset     = offset_q;
    assign length     = length_q;
    assign WR         = wr_q;
    assign writeData  = wdata_q;
    assign NewCommand = new_cmd_q;

endmodule

// File: doc/regio_arbiter.md
Name: regio_arbiter

Overview:
- Shares the single RegIO register-access port (offset/length/WR/writeData/NewCommand/readData) of the Ethernet controller bus among NUM_REQ requesters.
- Requester 0 is the initialization sequencer. Others are, for example, TX packet writer and interrupt/RX service.
- Replaces the static init_done-controlled muxes with a sequenced arbiter:
  - only requester 0 is served before init_done;
  - round-robin among eligible requesters afterwards;
  - optional lock for multi-command bursts;
  - timeout guard on each access.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 is the init requester
TIMEOUT_CYCLES, 255, maximum WAIT-state cycles before an access is aborted (1..255)

Ports:
clk40m  input  1  system clock, 40 MHz
reset  input  1  asynchronous active-low reset
init_done  input  1  1 = initialization complete, all requesters eligible
req  input  NUM_REQ  per-requester access request, held until ack
req_lock  input  NUM_REQ  keep grant after this access (burst)
req_offset  input  NUM_REQ*8  packed register offsets, requester i at [8i+7:8i]
req_length  input  NUM_REQ  0 = byte, 1 = word
req_wr  input  NUM_REQ  1 = write, 0 = read
req_wdata  input  NUM_REQ*16  packed write data, requester i at [16i+15:16i]
grant  output  NUM_REQ  one-hot current owner, 0 when idle
ack  output  NUM_REQ  one-cycle completion pulse to the owner
err  output  NUM_REQ  one-cycle timeout flag, coincident with ack
rdata  output  16  read data, valid while ack is high
offset  output  8  to RegIO
length  output  1  to RegIO
WR  output  1  to RegIO
writeData  output  16  to RegIO
NewCommand  output  1  to RegIO, one-cycle start strobe
readData  input  16  from RegIO
io_done  input  1  from RegIO, one-cycle pulse when the access completes; readData valid

Behaviour:
- Reset (reset=0, asynchronous):
  - all outputs 0, state IDLE;
  - round-robin pointer 0, lock cleared, timer 0.
- All outputs are registered.
- offset, length, WR and writeData hold their last latched value when not in use.
- FSM has four states: IDLE, ISSUE, WAIT, DONE.
- IDLE, eligibility:
  - eligible = req masked to bit 0 only when init_done=0;
  - eligible = req (all bits) when init_done=1.
- IDLE, lock handling:
  - If the lock is valid and req[lock_owner]=1: grant lock_owner, no rotation.
  - If the lock is valid and req[lock_owner]=0: clear the lock and arbitrate normally in the same cycle.
- IDLE, normal arbitration:
  - search eligible from the pointer upward, wrapping; the first set bit wins;
  - on a win, latch that requester's offset/length/wr/wdata into the RegIO outputs, set grant one-hot, and go to ISSUE;
  - if nothing is eligible, stay in IDLE with grant=0.
- ISSUE: NewCommand=1 for exactly this cycle, timer cleared, then go to WAIT.
- WAIT:
  - timer increments each cycle;
  - on io_done=1: rdata<=readData (writes capture readData too), go to DONE with err=0;
  - when timer reaches TIMEOUT_CYCLES with no io_done: rdata<=0, go to DONE with err=1.
  - io_done wins if it arrives in the same cycle as the timeout.
- DONE:
  - ack[owner]=1 for exactly one cycle; err[owner]=1 if timed out;
  - lock_valid<=req_lock[owner], lock_owner<=owner;
  - pointer<=owner+1, wrapping at NUM_REQ;
  - grant held through DONE, then cleared on return to IDLE.
- Latency: req sampled in IDLE at cycle 0 → NewCommand at cycle 1. io_done at cycle k → ack at cycle k+1 → IDLE at cycle k+2.
- Requester contract:
  - hold req and command fields stable from raise until ack;
  - a locked requester presents its next command in the cycle after ack, with req kept high.
- Boundaries:
  - io_done outside WAIT is ignored.
  - req dropped by the owner mid-access does not abort; ack is still pulsed.
  - init_done falling affects only the next arbitration; any lock held by requester ≥1 is cleared when init_done=0.
  - The pointer skipping a non-eligible index is allowed.

Test Plan:
1. init_done=0, req=3'b111, io_done 2 cycles after each NewCommand → only grant=3'b001 is issued, repeated. Then raise init_done → grants follow 001, 010, 100 round-robin.
2. init_done=1, req[1] and req[2] held continuously → grant sequence 010, 100, 010, 100. Exactly one NewCommand per access, 1 cycle wide.
3. req[1] with req_lock=1 for 4 commands while req[2] is pending, then lock=0 → four consecutive grants to 010, then 100. No NewCommand for requester 2 during the burst.
4. Requester 2 reads offset 8'h10 word (length=1, WR=0); io_done with readData=16'h8872 at cycle 4 → offset=8'h10 on the RegIO port, ack[2] at cycle 5 with rdata=16'h8872, err=0.
5. TIMEOUT_CYCLES=16, no io_done → ack[g]=err[g]=1 after 16 WAIT cycles, rdata=0. The next pending requester is granted 2 cycles later.
6. Assert reset=0 during WAIT, release it, then pulse io_done → all outputs 0 immediately on reset, no ack after release, FSM stays IDLE.
